// File: rtl/mux2_sel_reg_if.sv
// Bundle of the data inputs, select, and load enable, plus the combinational and registered results of mux2_sel_reg.
// The master drives the operands and the controls; the slave (the selector) drives both results.
interface mux2_sel_reg_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             S;
    logic             en;
    logic [WIDTH-1:0] O;
    logic [WIDTH-1:0] O_r;

    modport master (
        output A, B, S, en,
        input  O, O_r
    );

    modport slave (
        input  A, B, S, en,
        output O, O_r
    );
endinterface

// File: rtl/mux2_sel_reg.sv
// 2:1 selector with a zero-latency result O and a copy O_r, registered on the rising clock edge with a load enable.
// O never depends on clk, rst or en; O_r loads RST_VAL on a synchronous reset.
module mux2_sel_reg #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic            clk,
    input logic            rst,
    mux2_sel_reg_if.slave  bus
);
    logic [WIDTH-1:0] o_next;
    logic [WIDTH-1:0] o_r_reg;

    // The per-bit ternary lets bits where A and B agree stay known in simulation when S is X.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign o_next[gi] = bus.S ? bus.B[gi] : bus.A[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            o_r_reg <= RST_VAL;
        end else if (bus.en) begin
            o_r_reg <= o_next;
        end
    end

    assign bus.O   = o_next;
    assign bus.O_r = o_r_reg;
endmodule

// File: tb/tb_mux2_sel_reg.sv
// Self-checking bench for mux2_sel_reg: it runs a 1-bit and an 8-bit instance side by side.
// Both instances are checked against a selection-rule reference model, using directed cases followed by random traffic.
module tb_mux2_sel_reg;
    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst = 1'b0;

    mux2_sel_reg_if #(.WIDTH(1)) n_if ();
    mux2_sel_reg_if #(.WIDTH(8)) w_if ();

    mux2_sel_reg #(.WIDTH(1), .RST_VAL(1'b0)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (n_if.slave)
    );

    mux2_sel_reg #(.WIDTH(8), .RST_VAL(8'hFF)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (w_if.slave)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl_n_r;
    logic [7:0] mdl_w_r;
    bit         seeded = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference selection: operand table indexed by the select value.
    function automatic logic [7:0] pick(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [7:0] opts [2];
        opts[0] = a;
        opts[1] = b;
        return opts[s];
    endfunction

    // Drive one transaction after the falling edge, check O, clock it, then check O_r.
    task automatic step(input string tag, input logic r, input logic e, input logic s,
                        input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        rst = r;
        n_if.A = a[0]; n_if.B = b[0]; n_if.S = s; n_if.en = e;
        w_if.A = a;    w_if.B = b;    w_if.S = s; w_if.en = e;
        #1;
        check({tag, ".n.O"}, {7'b0, n_if.O}, pick({7'b0, a[0]}, {7'b0, b[0]}, s));
        check({tag, ".w.O"}, w_if.O, pick(a, b, s));
        @(posedge clk);
        if (r) begin
            mdl_n_r = 8'h00;
            mdl_w_r = 8'hFF;
            seeded  = 1'b1;
        end else if (e) begin
            mdl_n_r = pick({7'b0, a[0]}, {7'b0, b[0]}, s);
            mdl_w_r = pick(a, b, s);
        end
        #1;
        if (seeded) begin
            check({tag, ".n.O_r"}, {7'b0, n_if.O_r}, mdl_n_r);
            check({tag, ".w.O_r"}, w_if.O_r, mdl_w_r);
            $display("txn %s rst=%0b en=%0b S=%0b A=%h B=%h O_r(n)=%0b O_r(w)=%h",
                     tag, r, e, s, a, b, n_if.O_r, w_if.O_r);
        end
    endtask

    initial begin
        logic [7:0] tt;
        logic [2:0] idx;
        tt = 8'b1101_1000;  // bit i = required O for (A,B,S) = i

        // Combinational truth table with the clock stopped.
        n_if.en = 1'b0;
        w_if.en = 1'b0; w_if.A = '0; w_if.B = '0; w_if.S = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            n_if.A = idx[2]; n_if.B = idx[1]; n_if.S = idx[0];
            #10;
            check($sformatf("tt%0d", i), {7'b0, n_if.O}, {7'b0, tt[i]});
            $display("txn tt A=%0b B=%0b S=%0b O=%0b", idx[2], idx[1], idx[0], n_if.O);
        end

        clk_run = 1'b1;

        step("rst", 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
        check("rst.n.O_r0", {7'b0, n_if.O_r}, 8'h00);
        check("rst.n.O1", {7'b0, n_if.O}, 8'h01);
        check("rst.w.O_rFF", w_if.O_r, 8'hFF);

        step("load1", 1'b0, 1'b1, 1'b1, 8'h00, 8'h01);
        check("load1.n", {7'b0, n_if.O_r}, 8'h01);
        step("load0", 1'b0, 1'b1, 1'b0, 8'h00, 8'h01);
        check("load0.n", {7'b0, n_if.O_r}, 8'h00);

        step("pre", 1'b0, 1'b1, 1'b1, 8'h00, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 1'b0, 1'b0, 8'h00, 8'h01);
            check("hold.n", {7'b0, n_if.O_r}, 8'h01);
        end
        step("unhold", 1'b0, 1'b1, 1'b0, 8'h00, 8'h01);
        check("unhold.n", {7'b0, n_if.O_r}, 8'h00);

        step("pre2", 1'b0, 1'b1, 1'b1, 8'h00, 8'h01);
        step("midrst", 1'b1, 1'b1, 1'b1, 8'h00, 8'h01);
        check("midrst.n", {7'b0, n_if.O_r}, 8'h00);
        step("follow", 1'b0, 1'b1, 1'b1, 8'h00, 8'h01);
        check("follow.n", {7'b0, n_if.O_r}, 8'h01);

        step("w_a5", 1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C);
        check("w_a5.O", w_if.O, 8'hA5);
        check("w_a5.O_r", w_if.O_r, 8'hA5);
        step("w_3c", 1'b0, 1'b1, 1'b1, 8'hA5, 8'h3C);
        check("w_3c.O", w_if.O, 8'h3C);
        check("w_3c.O_r", w_if.O_r, 8'h3C);
        step("w_rst", 1'b1, 1'b1, 1'b0, 8'hA5, 8'h3C);
        check("w_rst.O_r", w_if.O_r, 8'hFF);

        for (int i = 0; i < 200; i++) begin
            step($sformatf("rnd%0d", i),
                 logic'($urandom_range(0, 15) == 0),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux2_sel_reg.md
Name: mux2_sel_reg

Overview:
- 2:1 selector for single-bit (default) or multi-bit data operands.
- Provides a combinational output and a registered copy of that output.
- Used as a generic datapath steering element.
- The combinational path is the primary function; the registered path gives downstream logic a timing-clean version one cycle later.

Parameters:
- WIDTH, 1, bit width of A, B, O and O_r.
- RST_VAL, 0 (WIDTH bits), value loaded into O_r on reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  data input, selected when S=0.
- B  input  WIDTH  data input, selected when S=1.
- S  input  1  select.
- en  input  1  register load enable for O_r. Tie to 1 for plain pipelining.
- O  output  WIDTH  combinational result.
- O_r  output  WIDTH  registered result.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high. No asynchronous reset path exists.
- Combinational path:
  - O = A when S=0; O = B when S=1.
  - Purely combinational with zero latency. Independent of clk, rst and en.
  - O is valid without any clock running; rst does not affect O.
- X/unknown handling on S:
  - No special requirement for synthesis.
  - In simulation, O may go X when S is X, except when A==B, where O may equal A.
- Registered path, on each rising clk edge:
  - rst=1: O_r <= RST_VAL, regardless of en, S, A, B.
  - rst=0 and en=1: O_r <= (S ? B : A), sampled at that edge.
  - rst=0 and en=0: O_r holds its value.
- Latency: O_r equals the value O had just before the previous enabled clock edge, i.e. 1 cycle.
- Reset:
  - Before the first reset edge, O_r is undefined.
  - After one clk edge with rst=1, O_r = RST_VAL.
  - Reset asserted mid-stream takes effect at the next edge; prior data is discarded.
  - Reset deasserted: the first load occurs on the first edge with rst=0 and en=1.
- Simultaneous input changes: A, B and S changing together produce the new O after propagation only. There is no hold-off or glitch filtering requirement on O.
- Width rule: all data paths are exactly WIDTH bits. No extension or truncation.
- No internal state other than the O_r register.

Test Plan:
- Exhaustive combinational truth table, WIDTH=1, no clock:
  - Apply (A,B,S) = 000, 001, 010, 011, 100, 101, 110, 111, 10 time units apart.
  - Required O = 0, 0, 0, 1, 1, 0, 1, 1.
- Reset:
  - rst=1 for one clk edge with A=1, B=1, S=1, en=1 -> O_r=0. O stays 1 throughout.
- Registered load:
  - rst=0, en=1, A=0, B=1, S=1 -> O=1 immediately; O_r=1 after the next clk edge.
  - Then S=0 -> O=0 immediately; O_r=0 one edge later.
- Hold:
  - O_r=1, set en=0, change S so that O=0 -> O_r stays 1 across 3 edges.
  - Set en=1 -> O_r=0 after the next edge.
- Reset mid-operation:
  - O_r=1, assert rst together with en=1 -> O_r=0 at the next edge.
  - Deassert rst -> O_r follows O again from the following edge.
- Wide configuration:
  - WIDTH=8, A=8'hA5, B=8'h3C: S=0 -> O=8'hA5; S=1 -> O=8'h3C.
  - O_r tracks O with 1-cycle delay.
  - Reset with RST_VAL=8'hFF -> O_r=8'hFF.
